// File: rtl/vram_pkg.sv
// Shared types and sizing for the video-memory SRAM controller.
package vram_pkg;

   localparam int ADDRESS_WIDTH     = 17;
   localparam int DATA_WIDTH        = 8;
   localparam int VIDEO_READ_CYCLES = 2;
   localparam int WRITE_CYCLES      = 3;

   typedef enum logic [2:0] {
      IDLE,
      VIDEO_READ,
      MCU_READ,
      WRITE_SETUP,
      WRITE_STROBE,
      WRITE_HOLD
   } vram_state_t;

endpackage

// File: rtl/sram_bus_driver.sv
// Pad-facing register stage for the external asynchronous SRAM: registered
// address and active-low strobes, tristate data output, raw input byte.
module sram_bus_driver #(
   parameter int ADDRESS_WIDTH = vram_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = vram_pkg::DATA_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] addressNext,
   input  logic [DATA_WIDTH-1:0]    dataNext,
   input  logic                     chipEnableNext,
   input  logic                     outputEnableNext,
   input  logic                     writeEnableNext,
   input  logic                     driveNext,
   output logic [ADDRESS_WIDTH-1:0] sramAddress,
   inout  wire  [DATA_WIDTH-1:0]    sramDataBus,
   output logic                     sramChipEnable,
   output logic                     sramOutputEnable,
   output logic                     sramWriteEnable,
   output logic [DATA_WIDTH-1:0]    sampledData
);

   logic                  driveEnable;
   logic [DATA_WIDTH-1:0] dataOut;

   // Register every pad signal so the SRAM sees clean, aligned edges.
   // NOTE: the asynchronous reset drops WE and the bus driver at once, which
   // is what aborts a write strobe the moment reset rises.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sramAddress      <= '0;
         sramChipEnable   <= 1'b1;
         sramOutputEnable <= 1'b1;
         sramWriteEnable  <= 1'b1;
         driveEnable      <= 1'b0;
         dataOut          <= '0;
      end else begin
         sramAddress      <= addressNext;
         sramChipEnable   <= chipEnableNext;
         sramOutputEnable <= outputEnableNext;
         sramWriteEnable  <= writeEnableNext;
         driveEnable      <= driveNext;
         dataOut          <= dataNext;
      end
   end

   assign sramDataBus = driveEnable ? dataOut : {DATA_WIDTH{1'bz}};
   assign sampledData = sramDataBus;

endmodule

// File: rtl/vram_controller.sv
// Single-port SRAM arbiter: video scan-out reads first, then MCU writes,
// and otherwise a continuous refresh of the MCU read-back byte.
module vram_controller #(
   parameter int ADDRESS_WIDTH = vram_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = vram_pkg::DATA_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     memoryWriteRequest,
   input  logic [ADDRESS_WIDTH-1:0] memoryWriteAddress,
   input  logic [DATA_WIDTH-1:0]    memoryWriteData,
   output logic                     memoryWriteComplete,
   input  logic [ADDRESS_WIDTH-1:0] memoryReadAddress,
   output logic [DATA_WIDTH-1:0]    memoryReadData,
   input  logic                     videoReadRequest,
   input  logic [ADDRESS_WIDTH-1:0] videoReadAddress,
   output logic [DATA_WIDTH-1:0]    videoReadData,
   output logic                     videoReadValid,
   output logic                     videoReadOverrun,
   output logic [ADDRESS_WIDTH-1:0] sramAddress,
   inout  wire  [DATA_WIDTH-1:0]    sramDataBus,
   output logic                     sramChipEnable,
   output logic                     sramOutputEnable,
   output logic                     sramWriteEnable
);

   import vram_pkg::*;

   localparam int PHASE_WIDTH = $clog2(VIDEO_READ_CYCLES);

   vram_state_t              state;
   vram_state_t              nextState;
   vram_state_t              selectedState;
   logic [PHASE_WIDTH-1:0]   readPhase;
   logic                     readLast;
   logic                     pending;
   logic [ADDRESS_WIDTH-1:0] pendingAddress;
   logic                     writeAcked;
   logic                     clearingPending;
   logic                     videoWanted;
   logic                     writeWanted;

   logic [ADDRESS_WIDTH-1:0] addressNext;
   logic [DATA_WIDTH-1:0]    dataNext;
   logic                     chipEnableNext;
   logic                     outputEnableNext;
   logic                     writeEnableNext;
   logic                     driveNext;
   logic [DATA_WIDTH-1:0]    sampledData;

   assign readLast        = (readPhase == PHASE_WIDTH'(VIDEO_READ_CYCLES - 1));
   assign clearingPending = (state == VIDEO_READ) && readLast;

   // Arbitration, next state and the pad values for the state being entered.
   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      videoWanted      = videoReadRequest || (pending && !clearingPending);
      writeWanted      = memoryWriteRequest && !writeAcked;
      selectedState    = MCU_READ;
      nextState        = state;
      addressNext      = '0;
      dataNext         = memoryWriteData;
      chipEnableNext   = 1'b1;
      outputEnableNext = 1'b1;
      writeEnableNext  = 1'b1;
      driveNext        = 1'b0;

      if (videoWanted) begin
         selectedState = VIDEO_READ;
      end else if (writeWanted) begin
         selectedState = WRITE_SETUP;
      end

      case (state)
         IDLE:         nextState = selectedState;
         VIDEO_READ,
         MCU_READ:     if (readLast) nextState = selectedState;
         WRITE_SETUP:  nextState = WRITE_STROBE;
         WRITE_STROBE: nextState = WRITE_HOLD;
         WRITE_HOLD:   nextState = IDLE;
         default:      nextState = IDLE;
      endcase

      case (nextState)
         VIDEO_READ: begin
            // A pulse arriving now supersedes the pending address, so an
            // overrun mid-read returns the newer byte.
            addressNext      = videoReadRequest ? videoReadAddress : pendingAddress;
            chipEnableNext   = 1'b0;
            outputEnableNext = 1'b0;
         end
         MCU_READ: begin
            addressNext      = memoryReadAddress;
            chipEnableNext   = 1'b0;
            outputEnableNext = 1'b0;
         end
         WRITE_SETUP,
         WRITE_HOLD: begin
            addressNext    = memoryWriteAddress;
            chipEnableNext = 1'b0;
            driveNext      = 1'b1;
         end
         WRITE_STROBE: begin
            addressNext     = memoryWriteAddress;
            chipEnableNext  = 1'b0;
            writeEnableNext = 1'b0;
            driveNext       = 1'b1;
         end
         default: ;
      endcase
   end

   // State register and the read-cycle phase counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         readPhase <= '0;
      end else begin
         state     <= nextState;
         readPhase <= ((state == VIDEO_READ || state == MCU_READ) && !readLast)
                      ? readPhase + 1'b1 : '0;
      end
   end

   // One-entry video request buffer with sticky overrun detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending          <= 1'b0;
         pendingAddress   <= '0;
         videoReadOverrun <= 1'b0;
      end else if (videoReadRequest) begin
         pending        <= 1'b1;
         pendingAddress <= videoReadAddress;
         if (pending && !clearingPending) begin
            videoReadOverrun <= 1'b1;
         end
      end else if (clearingPending) begin
         pending <= 1'b0;
      end
   end

   // Blocks a second write until the writer has dropped its request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         writeAcked <= 1'b0;
      end else if (state == WRITE_HOLD) begin
         writeAcked <= 1'b1;
      end else if (!memoryWriteRequest) begin
         writeAcked <= 1'b0;
      end
   end

   // Capture read bytes on the last read cycle and flag video data valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         videoReadData  <= '0;
         videoReadValid <= 1'b0;
         memoryReadData <= '0;
      end else begin
         videoReadValid <= 1'b0;
         if (state == VIDEO_READ && readLast) begin
            videoReadData  <= sampledData;
            videoReadValid <= 1'b1;
         end
         if (state == MCU_READ && readLast) begin
            memoryReadData <= sampledData;
         end
      end
   end

   assign memoryWriteComplete = (state == WRITE_HOLD);

   sram_bus_driver #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH)
   ) busDriver (
      .clock           (clock),
      .reset           (reset),
      .addressNext     (addressNext),
      .dataNext        (dataNext),
      .chipEnableNext  (chipEnableNext),
      .outputEnableNext(outputEnableNext),
      .writeEnableNext (writeEnableNext),
      .driveNext       (driveNext),
      .sramAddress     (sramAddress),
      .sramDataBus     (sramDataBus),
      .sramChipEnable  (sramChipEnable),
      .sramOutputEnable(sramOutputEnable),
      .sramWriteEnable (sramWriteEnable),
      .sampledData     (sampledData)
   );

endmodule
